// File: rtl/ysyx_23060191_mem_slave.sv
// Word-organised memory responder on an AXI4-Lite-style valid/ready bus.
// One transaction in flight, fixed read/write latency, byte-strobed writes, SLVERR outside the window.
module ysyx_23060191_mem_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           RD_LATENCY = 1,
  parameter int unsigned           WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  localparam int unsigned STRB_W  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
  localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT - 1) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'((WR_LATENCY > 1) ? WR_LATENCY - 2 : 0);
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(1) << (DEPTH_LOG2 + 2);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    acc_ok;
  logic [DEPTH_LOG2-1:0]   acc_idx;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   ar_off, aw_off;
  logic                    ar_map, aw_map;
  logic [DEPTH_LOG2-1:0]   ar_idx, aw_idx;
  logic                    ar_hs, w_hs;

  // Address decode: inside [BASE_ADDR, BASE_ADDR + 4*DEPTH), low two bits ignored
  assign ar_off = araddr - BASE_ADDR;
  assign aw_off = awaddr - BASE_ADDR;
  assign ar_map = (araddr >= BASE_ADDR) && ({1'b0, ar_off} < SPAN);
  assign aw_map = (awaddr >= BASE_ADDR) && ({1'b0, aw_off} < SPAN);
  assign ar_idx = ar_off[DEPTH_LOG2+1:2];
  assign aw_idx = aw_off[DEPTH_LOG2+1:2];

  // Reads take priority; AW and W are only ever accepted as a pair
  assign arready = (state == IDLE);
  assign awready = (state == IDLE) & ~arvalid & awvalid & wvalid;
  assign wready  = awready;
  assign ar_hs   = arvalid & arready;
  assign w_hs    = awready;

  always_ff @(posedge clk) begin
    if (w_hs && aw_map) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[aw_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc_ok  <= 1'b0;
      acc_idx <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            acc_ok  <= ar_map;
            acc_idx <= ar_idx;
            if (RD_LATENCY > 1) begin
              state <= RD_WAIT;
              cnt   <= RD_LOAD;
            end else begin
              state  <= RD_RESP;
              rvalid <= 1'b1;
              rdata  <= ar_map ? mem[ar_idx] : '0;
              rresp  <= ar_map ? RESP_OKAY : RESP_SLVERR;
            end
          end else if (w_hs) begin
            acc_ok <= aw_map;
            if (WR_LATENCY > 1) begin
              state <= WR_WAIT;
              cnt   <= WR_LOAD;
            end else begin
              state  <= WR_RESP;
              bvalid <= 1'b1;
              bresp  <= aw_map ? RESP_OKAY : RESP_SLVERR;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state  <= RD_RESP;
            rvalid <= 1'b1;
            rdata  <= acc_ok ? mem[acc_idx] : '0;
            rresp  <= acc_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (rready) begin
            state  <= IDLE;
            rvalid <= 1'b0;
          end
        end
        WR_WAIT: begin
          if (cnt == '0) begin
            state  <= WR_RESP;
            bvalid <= 1'b1;
            bresp  <= acc_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR_RESP: begin
          if (bready) begin
            state  <= IDLE;
            bvalid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_mem_slave.sv
// Bench for ysyx_23060191_mem_slave: directed scenarios plus random traffic against a word-map model.
// Instance 0 uses read/write latency 3/2, instance 1 uses 1/1.
module tb_ysyx_23060191_mem_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] SPAN = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr [2];
  logic [31:0] awaddr [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  rresp  [2];
  logic [1:0]  bresp  [2];
  logic        arvalid[2], arready[2], rvalid[2], rready[2];
  logic        awvalid[2], awready[2], wvalid[2], wready[2];
  logic        bvalid [2], bready [2];

  ysyx_23060191_mem_slave #(.RD_LATENCY(3), .WR_LATENCY(2)) u0 (
    .clk(clk), .rst(rst),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wready(wready[0]),
    .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0])
  );

  ysyx_23060191_mem_slave #(.RD_LATENCY(1), .WR_LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wready(wready[1]),
    .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1])
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [31:0] refm [longint];
  logic [31:0] pool [8];

  function automatic int rd_lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic int wr_lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit mapped(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < SPAN);
  endfunction

  function automatic longint key(input int d, input logic [31:0] a);
    return (longint'(d) << 32) | longint'({a[31:2], 2'b00});
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input int d, input logic [31:0] a, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] w;
    if (!mapped(a)) return;
    w = refm.exists(key(d, a)) ? refm[key(d, a)] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (strb[i]) w[8*i +: 8] = data[8*i +: 8];
    refm[key(d, a)] = w;
  endtask

  // Full read transaction; caller is at a negedge, returns at a negedge
  task automatic rd(input int d, input logic [31:0] a, input int stall, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    int n;
    ed = mapped(a) ? refm[key(d, a)] : 32'h0;
    er = mapped(a) ? 2'b00 : 2'b10;
    n = 0;
    while (arready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s arready", tag), 32'(arready[d]), 32'd1);
    araddr[d] = a; arvalid[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid[d] = 1'b0; araddr[d] = 32'h0;
    n = 1;
    while (rvalid[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s rlat", tag), 32'(n), 32'(rd_lat(d)));
    chk($sformatf("%s rdata", tag), rdata[d], ed);
    chk($sformatf("%s rresp", tag), 32'(rresp[d]), 32'(er));
    repeat (stall) begin
      @(negedge clk);
      chk($sformatf("%s rvalid held", tag), 32'(rvalid[d]), 32'd1);
      chk($sformatf("%s rdata held", tag), rdata[d], ed);
    end
    rready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    rready[d] = 1'b0;
    chk($sformatf("%s rvalid drop", tag), 32'(rvalid[d]), 32'd0);
    chk($sformatf("%s arready back", tag), 32'(arready[d]), 32'd1);
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [31:0] data,
                    input logic [3:0] strb, input int stall, input string tag);
    logic [1:0] er;
    int n;
    er = mapped(a) ? 2'b00 : 2'b10;
    awaddr[d] = a; wdata[d] = data; wstrb[d] = strb;
    awvalid[d] = 1'b1; wvalid[d] = 1'b1;
    #1;
    n = 0;
    while (awready[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s awready", tag), 32'({awready[d], wready[d]}), 32'd3);
    model_write(d, a, data, strb);
    @(posedge clk); @(negedge clk);
    awvalid[d] = 1'b0; wvalid[d] = 1'b0;
    n = 1;
    while (bvalid[d] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk($sformatf("%s blat", tag), 32'(n), 32'(wr_lat(d)));
    chk($sformatf("%s bresp", tag), 32'(bresp[d]), 32'(er));
    repeat (stall) begin
      @(negedge clk);
      chk($sformatf("%s bvalid held", tag), 32'({bvalid[d], bresp[d]}), 32'({1'b1, er}));
    end
    bready[d] = 1'b1;
    @(posedge clk); @(negedge clk);
    bready[d] = 1'b0;
    chk($sformatf("%s bvalid drop", tag), 32'(bvalid[d]), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      araddr[d] = '0; arvalid[d] = 1'b0; rready[d] = 1'b0;
      awaddr[d] = '0; awvalid[d] = 1'b0; wdata[d] = '0; wstrb[d] = '0;
      wvalid[d] = 1'b0; bready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset%0d rvalid", d), 32'(rvalid[d]), 32'd0);
      chk($sformatf("reset%0d bvalid", d), 32'(bvalid[d]), 32'd0);
      chk($sformatf("reset%0d rdata", d), rdata[d], 32'h0);
      chk($sformatf("reset%0d resps", d), 32'({rresp[d], bresp[d]}), 32'd0);
      chk($sformatf("reset%0d ready", d), 32'({arready[d], awready[d], wready[d]}), 32'b100);
    end

    // Basic write then read back
    wr(0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "w10");
    rd(0, BASE + 32'h10, 0, "r10");

    // Byte-lane merge over preloaded word
    wr(0, BASE + 32'h20, 32'h1122_3344, 4'hF, 0, "pre20");
    wr(0, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, 1, "w20");
    rd(0, BASE + 32'h20, 0, "r20");
    chk("merge model", refm[key(0, BASE + 32'h20)], 32'h11BB_33DD);
    wr(0, BASE + 32'h24, 32'h5555_6666, 4'hF, 0, "pre24");
    wr(0, BASE + 32'h24, 32'hFFFF_FFFF, 4'h0, 0, "w24z");
    rd(0, BASE + 32'h24, 0, "r24");

    // Unmapped accesses; 0x8000_4000 would alias word 0 if decode wrapped
    wr(0, BASE, 32'h0123_4567, 4'hF, 0, "pre0");
    rd(0, 32'h7FFF_FFFC, 0, "rlow");
    wr(0, 32'h8000_4000, 32'hCAFE_F00D, 4'hF, 0, "whigh");
    rd(0, BASE, 0, "r0");
    wr(0, BASE + 32'h3FFC, 32'h0BAD_CAFE, 4'hF, 0, "wlast");
    rd(0, BASE + 32'h3FFF, 0, "rlast");

    // Read and write offered together: read wins, write waits
    araddr[0] = BASE + 32'h20; arvalid[0] = 1'b1;
    awaddr[0] = BASE + 32'h30; wdata[0] = 32'h0BAD_F00D; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    #1;
    chk("sim ready", 32'({arready[0], awready[0], wready[0]}), 32'b100);
    @(posedge clk); @(negedge clk);
    arvalid[0] = 1'b0;
    n = 1;
    while (rvalid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("sim rlat", 32'(n), 32'd3);
    chk("sim rdata", rdata[0], 32'h11BB_33DD);
    chk("sim awready held", 32'({awready[0], wready[0]}), 32'd0);
    rready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    rready[0] = 1'b0;
    chk("sim awready after r", 32'({awready[0], wready[0]}), 32'd3);
    model_write(0, BASE + 32'h30, 32'h0BAD_F00D, 4'hF);
    @(posedge clk); @(negedge clk);
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    n = 1;
    while (bvalid[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("sim blat", 32'(n), 32'd2);
    chk("sim bresp", 32'(bresp[0]), 32'd0);
    bready[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    bready[0] = 1'b0;
    rd(0, BASE + 32'h30, 0, "sim rback");

    // Read stalled by requester
    rd(0, BASE + 32'h10, 4, "stall");

    // Reset during the read wait
    araddr[0] = BASE + 32'h10; arvalid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst rvalid", 32'(rvalid[0]), 32'd0);
    chk("rst arready", 32'(arready[0]), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst no resp", 32'(rvalid[0]), 32'd0);
    end
    chk("rst arready after", 32'(arready[0]), 32'd1);
    rd(0, BASE + 32'h10, 0, "rst rd");

    // Random traffic on both latency configurations
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        pool[i] = BASE + {18'h0, 12'($urandom_range(0, 4095)), 2'b00};
        wr(d, pool[i], $urandom, 4'hF, 0, "rnd init");
      end
      for (int i = 0; i < 40; i++) begin
        n = $urandom_range(0, 9);
        a = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
        if (n >= 8) begin
          a = $urandom;
          if (mapped(a)) a = a + SPAN;
        end
        if (n < 4 || n == 9)
          wr(d, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rnd wr");
        else
          rd(d, a, $urandom_range(0, 2), "rnd rd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
